// File: rtl/twiddle_quarter_rom_if.sv
// -----------------------------------------------------------------------------
// twiddle_quarter_rom_if
//   Request / result bundle between the FFT stage controller (master) and the
//   quarter-wave twiddle generator (slave).
//
//   Request channel (master -> slave, valid/ready):
//     in_valid  request valid
//     in_ready  request accepted when in_valid && in_ready (slave -> master)
//     in_idx    twiddle index k, full circle 0..N-1
//     in_shift  stride shift, effective index e = (k << in_shift) mod N
//     in_inv    0 = forward exp(-j*theta), 1 = inverse exp(+j*theta)
//
//   Result channel (slave -> master, valid/ready):
//     out_valid result valid
//     out_ready consumer ready (master -> slave)
//     W_re      real part, signed K-bit
//     W_im      imaginary part, signed K-bit
// -----------------------------------------------------------------------------
interface twiddle_quarter_rom_if #(
    parameter int LOG_N = 12,
    parameter int SH_W  = 5,
    parameter int K     = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LOG_N-1:0]        in_idx;
    logic [SH_W-1:0]         in_shift;
    logic                    in_inv;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [K-1:0]     W_re;
    logic signed [K-1:0]     W_im;

    modport master (
        output in_valid, in_idx, in_shift, in_inv, out_ready,
        input  in_ready, out_valid, W_re, W_im
    );

    modport slave (
        input  in_valid, in_idx, in_shift, in_inv, out_ready,
        output in_ready, out_valid, W_re, W_im
    );
endinterface

// File: rtl/twiddle_quarter_rom.sv
// -----------------------------------------------------------------------------
// twiddle_quarter_rom
//   FFT twiddle-factor generator W = exp(-/+ j*2*pi*k/N) in signed K-bit fixed
//   point, built from a quarter-wave cosine table of N/4+1 words. The table is
//   filled at elaboration from $cos, scaled by 2^(K-1)-1 and rounded half away
//   from zero, so every entry can be negated without overflow.
//
//   Three-stage pipeline, one request per cycle, full backpressure:
//     stage 1: effective index e = (k << shift) mod N, split into quadrant q
//              and in-quadrant offset r
//     stage 2: read a = C[r] and b = C[N/4 - r] (two read ports)
//     stage 3: quadrant fold and forward/inverse sign, registered outputs
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous reset, active low; clears valids and outputs
//     bus    twiddle_quarter_rom_if.slave (request and result channels)
//
//   Parameters:
//     N      transform length, power of two, >= 8
//     K      output word width
//     LOG_N  index width (derived)
//     SH_W   stride-shift width (derived)
// -----------------------------------------------------------------------------
module twiddle_quarter_rom #(
    parameter int  N     = 4096,
    parameter int  K     = 16,
    localparam int LOG_N = $clog2(N),
    localparam int SH_W  = $clog2(LOG_N) + 1
) (
    input logic                  clk,
    input logic                  rst_n,
    twiddle_quarter_rom_if.slave bus
);

    localparam int  Q      = N / 4;
    localparam int  R_W    = LOG_N - 2;
    localparam int  A_W    = LOG_N - 1;
    localparam real PI_R   = 3.14159265358979323846;
    localparam real AMP_R  = (2.0 ** (K - 1)) - 1.0;
    localparam logic [A_W-1:0] Q_ADDR = A_W'(Q);

    // -------------------------------------------------------------------------
    // Quarter-wave cosine table, C[m] for m = 0..N/4. All entries are >= 0;
    // the sign branch only guards against a tiny negative cos(pi/2) result.
    // -------------------------------------------------------------------------
    logic signed [K-1:0] rom_s [0:Q];

    for (genvar m = 0; m <= Q; m++) begin : g_rom
        localparam real VAL_R = AMP_R * $cos(2.0 * PI_R * real'(m) / real'(N));
        localparam int  RND_I = (VAL_R >= 0.0) ? $rtoi(VAL_R + 0.5)
                                               : -$rtoi(0.5 - VAL_R);
        assign rom_s[m] = K'(RND_I);
    end

    // Pipeline advance: everything moves when the output slot is free or
    // being drained this cycle, and holds otherwise.
    logic en_s;
    assign en_s         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en_s;

    // Stride shift; shifting by LOG_N or more naturally yields e = 0 because
    // the result is truncated to LOG_N bits (this truncation is the mod N).
    logic [SH_W-1:0]  shift_s;
    logic [LOG_N-1:0] e_s;
    assign shift_s = bus.in_shift;
    assign e_s     = LOG_N'(bus.in_idx << shift_s);

    // Stage 1 registers
    logic             v1_r;
    logic [1:0]       q1_r;
    logic [R_W-1:0]   r1_r;
    logic             inv1_r;

    // Stage 2 registers
    logic                v2_r;
    logic [1:0]          q2_r;
    logic                inv2_r;
    logic signed [K-1:0] a2_r;
    logic signed [K-1:0] b2_r;

    // Table addresses: r = 0 reads C[N/4] (= 0) on the second port.
    logic [A_W-1:0] addr_a_s;
    logic [A_W-1:0] addr_b_s;
    assign addr_a_s = {1'b0, r1_r};
    assign addr_b_s = Q_ADDR - {1'b0, r1_r};

    // Stage 1: accept the request and split the effective index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            q1_r   <= 2'd0;
            r1_r   <= '0;
            inv1_r <= 1'b0;
        end else if (en_s) begin
            v1_r   <= bus.in_valid;
            q1_r   <= e_s[LOG_N-1 -: 2];
            r1_r   <= e_s[R_W-1:0];
            inv1_r <= bus.in_inv;
        end
    end

    // Stage 2: dual-port table read of C[r] and C[N/4 - r].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r   <= 1'b0;
            q2_r   <= 2'd0;
            inv2_r <= 1'b0;
            a2_r   <= '0;
            b2_r   <= '0;
        end else if (en_s) begin
            v2_r   <= v1_r;
            q2_r   <= q1_r;
            inv2_r <= inv1_r;
            a2_r   <= rom_s[addr_a_s];
            b2_r   <= rom_s[addr_b_s];
        end
    end

    // Quadrant fold: cos/sin of the full angle from the quarter-wave pair.
    logic signed [K-1:0] cos_s;
    logic signed [K-1:0] sin_s;
    logic signed [K-1:0] im_s;

    // Combinational quadrant mapping and forward/inverse sign selection.
    always_comb begin
        cos_s = a2_r;
        sin_s = b2_r;
        case (q2_r)
            2'd0: begin
                cos_s = a2_r;
                sin_s = b2_r;
            end
            2'd1: begin
                cos_s = -b2_r;
                sin_s = a2_r;
            end
            2'd2: begin
                cos_s = -a2_r;
                sin_s = -b2_r;
            end
            2'd3: begin
                cos_s = b2_r;
                sin_s = -a2_r;
            end
            default: begin
                cos_s = a2_r;
                sin_s = b2_r;
            end
        endcase
        // Forward transform uses exp(-j*theta), hence the negated sine.
        if (inv2_r) begin
            im_s = sin_s;
        end else begin
            im_s = -sin_s;
        end
    end

    // Stage 3: registered outputs; a bubble clears out_valid but leaves the
    // last result on W_re/W_im untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.W_re      <= '0;
            bus.W_im      <= '0;
        end else if (en_s) begin
            bus.out_valid <= v2_r;
            if (v2_r) begin
                bus.W_re <= cos_s;
                bus.W_im <= im_s;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_quarter_rom.sv
// -----------------------------------------------------------------------------
// tb_twiddle_quarter_rom
//   Scoreboard bench for twiddle_quarter_rom (N=4096, K=16). Requests sit in a
//   request queue; when one is accepted its expected result is pushed to the
//   scoreboard, and popped/compared when the DUT delivers a result. Expected
//   values come from the literal table values or from a full-circle
//   real-valued model computed here.
// -----------------------------------------------------------------------------
module tb_twiddle_quarter_rom;

    localparam int  N     = 4096;
    localparam int  K     = 16;
    localparam int  LOG_N = $clog2(N);
    localparam int  SH_W  = $clog2(LOG_N) + 1;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = 32767.0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    twiddle_quarter_rom_if #(.LOG_N(LOG_N), .SH_W(SH_W), .K(K)) bus ();

    twiddle_quarter_rom #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int    idx;
        int    shift;
        bit    inv;
        bit    use_model;
        int    exp_re;
        int    exp_im;
        string tag;
    } req_t;

    typedef struct {
        int    exp_re;
        int    exp_im;
        int    acc_cyc;
        bit    mag;
        string tag;
    } exp_t;

    req_t req_q[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return int'($floor(x + 0.5));
        else          return -int'($floor(0.5 - x));
    endfunction

    function automatic int eff_idx(input int idx, input int sh);
        longint v;
        if (sh >= LOG_N) return 0;
        v = longint'(idx) << sh;
        return int'(v % longint'(N));
    endfunction

    task automatic add_req(input int idx, input int sh, input bit inv,
                           input bit use_model, input int er, input int ei,
                           input string tag);
        req_t r;
        r.idx = idx; r.shift = sh; r.inv = inv; r.use_model = use_model;
        r.exp_re = er; r.exp_im = ei; r.tag = tag;
        req_q.push_back(r);
    endtask

    // Turn an accepted request into its scoreboard entry.
    function automatic exp_t make_exp(input req_t r, input int cyc);
        exp_t e;
        real  th;
        int   c, s;
        e.tag     = r.tag;
        e.acc_cyc = cyc;
        e.mag     = r.use_model;
        if (r.use_model) begin
            th = 2.0 * PI * real'(eff_idx(r.idx, r.shift)) / real'(N);
            c  = rnd(AMP * $cos(th));
            s  = rnd(AMP * $sin(th));
            e.exp_re = c;
            e.exp_im = r.inv ? s : -s;
        end else begin
            e.exp_re = r.exp_re;
            e.exp_im = r.exp_im;
        end
        return e;
    endfunction

    // Drive the request queue and drain results until both queues are empty.
    // bp_cycles > 0 holds out_ready low that many cycles from the first
    // out_valid; with bp_cycles == 0 every result must come exactly 3 cycles
    // after its accept.
    task automatic run_stream(input int bp_cycles, input int budget);
        int                  cyc = 0;
        int                  bp_left = bp_cycles;
        bit                  bp_armed = (bp_cycles > 0);
        bit                  holding = 1'b0;
        logic signed [K-1:0] hold_re = '0;
        logic signed [K-1:0] hold_im = '0;
        exp_t                e;
        longint              m2, d;
        while ((req_q.size() != 0 || sb_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            if (bp_armed && bus.out_valid) begin
                bp_armed = 1'b0;
                holding  = 1'b1;
                hold_re  = bus.W_re;
                hold_im  = bus.W_im;
            end
            if (holding && bp_left > 0) begin
                bus.out_ready = 1'b0;
                bp_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (req_q.size() != 0) begin
                bus.in_valid = 1'b1;
                bus.in_idx   = LOG_N'(req_q[0].idx);
                bus.in_shift = SH_W'(req_q[0].shift);
                bus.in_inv   = req_q[0].inv;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(make_exp(req_q[0], cyc));
                void'(req_q.pop_front());
            end
            if (!bus.out_ready) begin
                check_val("stall_in_ready", bus.in_ready, 0);
                check_val("stall_out_valid", bus.out_valid, 1);
                check_val("stall_re_frozen", bus.W_re, hold_re);
                check_val("stall_im_frozen", bus.W_im, hold_im);
            end else if (bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_output", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_val({e.tag, "_re"}, bus.W_re, e.exp_re);
                    check_val({e.tag, "_im"}, bus.W_im, e.exp_im);
                    if (bp_cycles == 0)
                        check_val({e.tag, "_latency"}, cyc - e.acc_cyc, 3);
                    if (e.mag) begin
                        m2 = longint'(bus.W_re) * bus.W_re + longint'(bus.W_im) * bus.W_im;
                        d  = m2 - 64'sd1073676289;
                        if (d < 0) d = -d;
                        check_val({e.tag, "_mag"}, (d <= 64'sd107367) ? 1 : 0, 1);
                    end
                end
            end
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (cyc >= budget) begin
            check_val("stream_timeout", cyc, -1);
            req_q.delete();
            sb_q.delete();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_shift  = '0;
        bus.in_inv    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_w_re", bus.W_re, 0);
        check_val("rst_w_im", bus.W_im, 0);
        check_val("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Forward, back-to-back, table values
        add_req(0,    0, 1'b0, 1'b0,  32767,      0, "fwd_0");
        add_req(512,  0, 1'b0, 1'b0,  23170, -23170, "fwd_512");
        add_req(1024, 0, 1'b0, 1'b0,      0, -32767, "fwd_1024");
        add_req(1536, 0, 1'b0, 1'b0, -23170, -23170, "fwd_1536");
        add_req(2048, 0, 1'b0, 1'b0, -32767,      0, "fwd_2048");
        // Inverse, same indices
        add_req(0,    0, 1'b1, 1'b0,  32767,      0, "inv_0");
        add_req(512,  0, 1'b1, 1'b0,  23170,  23170, "inv_512");
        add_req(1024, 0, 1'b1, 1'b0,      0,  32767, "inv_1024");
        add_req(1536, 0, 1'b1, 1'b0, -23170,  23170, "inv_1536");
        add_req(2048, 0, 1'b1, 1'b0, -32767,      0, "inv_2048");
        // Stride shift
        add_req(1, 10, 1'b0, 1'b0,      0, -32767, "stride_1_10");
        add_req(3, 11, 1'b0, 1'b0, -32767,      0, "stride_3_11");
        add_req(3, 15, 1'b0, 1'b0,  32767,      0, "stride_3_15");
        add_req(4095, 1, 1'b1, 1'b1, 0, 0, "stride_4095_1");
        add_req(3071, 0, 1'b0, 1'b1, 0, 0, "wrap_3071");
        run_stream(0, 100);

        // Backpressure: 8 results, out_ready low for 4 cycles
        for (int i = 0; i < 8; i++)
            add_req(i, 0, 1'b0, 1'b1, 0, 0, $sformatf("bp_%0d", i));
        run_stream(4, 100);

        // Full sweep, both directions
        for (int v = 0; v < 2; v++)
            for (int k = 0; k < N; k++)
                add_req(k, 0, v[0], 1'b1, 0, 0, $sformatf("sweep_k%0d_inv%0d", k, v));
        run_stream(0, 2 * N + 100);

        // Reset with three requests in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_idx   = LOG_N'(512 * (i + 1));
            bus.in_shift = '0;
            bus.in_inv   = 1'b0;
            #1;
            check_val("flight_accept", bus.in_ready, 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check_val("flight_out_valid", bus.out_valid, 1);
        check_val("flight_w_re", bus.W_re, 23170);
        check_val("flight_w_im", bus.W_im, -23170);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", bus.out_valid, 0);
        check_val("midrst_w_re", bus.W_re, 0);
        check_val("midrst_w_im", bus.W_im, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check_val("post_rst_idle", bus.out_valid, 0);
        end
        add_req(1536, 0, 1'b1, 1'b0, -23170, 23170, "post_rst_1536");
        run_stream(0, 50);
        repeat (4) begin
            @(negedge clk);
            #1;
            check_val("post_rst_no_stale", bus.out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
